pipe_flow_ctrl: RTL and testbench
=================================

# pipe_flow_ctrl

Central flow controller for the five-stage pipeline. Every cycle it drives one 2-bit op to each pipeline register and one to the PC register: `PcOp`, `IfIdOp`, `IdExOp`, `ExMemOp` and `MemWbOp`. It resolves four conditions in a fixed priority order:

- multi-cycle memory waits;
- load-use data hazards;
- taken-branch flushes;
- the structural conflict between IF fetch and MEM access on the single shared memory bus.

It also keeps a wait-state FSM, a watchdog and performance counters.

## Interface
Parameters:
- `REG_W`, 5, register-number width.
- `MAX_WAIT`, 15, maximum consecutive memory wait cycles before the watchdog trips.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low.
- `id_rs_i`, `id_rt_i` in `REG_W`: source registers of the instruction in ID.
- `id_rs_used_i`, `id_rt_used_i` in 1: the corresponding source is actually read.
- `ex_load_i` in 1: the instruction in EX is a load.
- `ex_rd_i` in `REG_W`: destination register of the instruction in EX.
- `branch_taken_i` in 1: branch/jump resolved taken in ID this cycle.
- `mem_req_i` in 1: MEM stage uses the shared bus this cycle.
- `mem_ready_i` in 1: bus completes the MEM access this cycle.
- `pc_op_o`, `if_id_op_o`, `id_ex_op_o`, `ex_mem_op_o`, `mem_wb_op_o` out 2: stage ops.
- `mem_timeout_o` out 1: sticky watchdog flag.
- `stall_cycles_o` out 32: count of cycles in which `pc_op_o` != NORMAL.
- `flush_count_o` out 16: count of taken-branch flushes.

## Operation
Op encoding: `NORMAL_OP`=2'b00 (load), `KEEP_OP`=2'b01 (hold), `RST_OP`=2'b10 (load bubble: zero word / NOP).

FSM states are RUN and MEM_WAIT.

Hazard term:
- `lu` = `ex_load_i` && `ex_rd_i`!=0 && ((`id_rs_used_i` && `id_rs_i`==`ex_rd_i`) || (`id_rt_used_i` && `id_rt_i`==`ex_rd_i`)).

Ops are combinational from state and inputs. In RUN, the first matching rule wins:
1. `mem_req_i` && !`mem_ready_i`:
   - PC, IfId, IdEx, ExMem = KEEP; MemWb = RST.
   - Next state MEM_WAIT; wait counter loads 1.
2. `lu`:
   - PC, IfId = KEEP; IdEx = RST; ExMem, MemWb = NORMAL.
3. `branch_taken_i`:
   - PC = NORMAL (takes target); IfId = RST; rest NORMAL.
   - `flush_count_o`++.
   - Holds even when `mem_req_i`=1, because the fetched word is discarded anyway.
4. `mem_req_i` (ready same cycle): structural conflict, IF loses the bus.
   - PC = KEEP; IfId = RST; rest NORMAL.
5. Otherwise all ops NORMAL.

In MEM_WAIT:
- While !`mem_ready_i`:
  - Freeze ops as in rule 1.
  - Wait counter increments.
  - When the counter reaches `MAX_WAIT`: set `mem_timeout_o` and force all five ops to RST for that cycle. Next state is RUN.
- When `mem_ready_i`=1: evaluate rules 2–5 with `mem_req_i` treated as 1, so rule 4 applies if no higher rule matches. Next state is RUN.

Counters:
- `stall_cycles_o` wraps modulo 2^32.
- `flush_count_o` saturates at 16'hFFFF.
- `mem_timeout_o` clears only on reset.

## Timing
- Reset is sampled at `posedge clk`. While `rst`=0:
  - all ops = RST_OP;
  - state = RUN;
  - counters and `mem_timeout_o` = 0;
  - wait counter = 0.
- Ops are valid in the same cycle as the inputs: zero latency, sampled by the pipeline registers at the next edge.
- State, counters and the watchdog update at the clock edge; counters reflect the previous cycle.
- Reset asserted mid-wait aborts MEM_WAIT immediately, with no timeout flag.
- A `mem_ready_i` pulse without `mem_req_i` while in RUN is ignored.

## Structure
- Shared `defines`:
  - `NORMAL_OP`, `KEEP_OP`, `RST_OP`;
  - state encodings `ST_RUN` and `ST_MEM_WAIT`;
  - `ZeroWord`.
- Natural sub-module: `hazard_detect`, a combinational `lu` computation, reusable by a future forwarding unit.
- The FSM, watchdog and counters stay in the top block.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles.
  - All ops = 2'b10 and counters = 0.
  - After release with idle inputs, all ops = 2'b00.
- **Load-use:** `ex_load_i`=1, `ex_rd_i`=5, `id_rs_i`=5, `id_rs_used_i`=1.
  - PC/IfId = KEEP, IdEx = RST, `stall_cycles_o` +1 next cycle.
  - Repeat with `ex_rd_i`=0: all NORMAL.
- **Memory wait:** `mem_req_i`=1 and `mem_ready_i`=0 for 3 cycles, then 1.
  - 3 cycles of freeze ops with MemWb = RST.
  - Ready cycle gives PC = KEEP, IfId = RST.
  - Then RUN, with `stall_cycles_o`=4.
- **Branch plus structural conflict:** `branch_taken_i`=1 and `mem_req_i`=1 in the same cycle.
  - PC = NORMAL, IfId = RST.
  - `flush_count_o`=1.
- **Priority:** `lu` and `branch_taken_i` asserted together.
  - Load-use stall ops only; `flush_count_o` unchanged.
- **Watchdog:** `mem_req_i`=1 with `mem_ready_i` held 0 for 15 cycles.
  - Cycle 15: all ops = RST, `mem_timeout_o`=1, which stays set until reset.

Source files
------------

// File: rtl/pipe_flow_ctrl_pkg.sv
// Shared op encodings, FSM states and helpers for the pipeline flow controller.
package pipe_flow_ctrl_pkg;

   typedef enum logic [1:0] {
      NORMAL_OP = 2'b00,
      KEEP_OP   = 2'b01,
      RST_OP    = 2'b10
   } op_e;

   typedef enum logic {
      ST_RUN      = 1'b0,
      ST_MEM_WAIT = 1'b1
   } state_e;

   localparam logic [31:0] ZeroWord = 32'h0000_0000;

   typedef struct packed {
      op_e pc;
      op_e if_id;
      op_e id_ex;
      op_e ex_mem;
      op_e mem_wb;
   } stage_ops_t;

   function automatic stage_ops_t all_ops(input op_e op);
      stage_ops_t s;
      s.pc     = op;
      s.if_id  = op;
      s.id_ex  = op;
      s.ex_mem = op;
      s.mem_wb = op;
      return s;
   endfunction

   // Everything upstream of MEM holds; the stalled access must not retire into WB.
   function automatic stage_ops_t freeze_ops();
      stage_ops_t s;
      s        = all_ops(KEEP_OP);
      s.mem_wb = RST_OP;
      return s;
   endfunction

endpackage

// File: rtl/pipe_flow_ctrl_hazard_detect.sv
// Load-use hazard term: the load in EX writes a register the ID instruction reads.
module hazard_detect #(
   parameter int REG_W = 5
) (
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_rs_used_i,
   input  logic             id_rt_used_i,
   input  logic             ex_load_i,
   input  logic [REG_W-1:0] ex_rd_i,
   output logic             lu_o
);

   logic rs_hit;
   logic rt_hit;

   assign rs_hit = id_rs_used_i && (id_rs_i == ex_rd_i);
   assign rt_hit = id_rt_used_i && (id_rt_i == ex_rd_i);
   // Register zero is hardwired, so a load targeting it never creates a dependency.
   assign lu_o   = ex_load_i && (ex_rd_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_flow_ctrl.sv
// Pipeline flow controller: per-stage ops from memory waits, load-use, branch
// flushes and bus conflicts, plus wait-state watchdog and performance counters.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// ST_RUN       | normal issue; hazards resolved combinationally each cycle
// ST_MEM_WAIT  | MEM access outstanding; pipeline frozen until ready/watchdog
module pipe_flow_ctrl
   import pipe_flow_ctrl_pkg::*;
#(
   parameter int REG_W    = 5,
   parameter int MAX_WAIT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REG_W-1:0] id_rs_i,
   input  logic [REG_W-1:0] id_rt_i,
   input  logic             id_rs_used_i,
   input  logic             id_rt_used_i,
   input  logic             ex_load_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic             branch_taken_i,
   input  logic             mem_req_i,
   input  logic             mem_ready_i,
   output logic [1:0]       pc_op_o,
   output logic [1:0]       if_id_op_o,
   output logic [1:0]       id_ex_op_o,
   output logic [1:0]       ex_mem_op_o,
   output logic [1:0]       mem_wb_op_o,
   output logic             mem_timeout_o,
   output logic [31:0]      stall_cycles_o,
   output logic [15:0]      flush_count_o
);

   localparam int WAIT_W = $clog2(MAX_WAIT + 1);
   // Counter value at the start of the cycle that becomes the MAX_WAIT-th wait.
   localparam logic [WAIT_W-1:0] WAIT_TRIP = WAIT_W'(MAX_WAIT - 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              timeout_q, timeout_d;
   logic [31:0]       stall_q, stall_d;
   logic [15:0]       flush_q, flush_d;

   stage_ops_t ops;
   logic       lu;
   logic       resolve;
   logic       bus_busy;
   logic       flush_ev;

   hazard_detect #(.REG_W(REG_W)) u_hazard (
      .id_rs_i      (id_rs_i),
      .id_rt_i      (id_rt_i),
      .id_rs_used_i (id_rs_used_i),
      .id_rt_used_i (id_rt_used_i),
      .ex_load_i    (ex_load_i),
      .ex_rd_i      (ex_rd_i),
      .lu_o         (lu)
   );

   always_comb begin
      ops       = all_ops(NORMAL_OP);
      state_d   = state_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      resolve   = 1'b0;
      bus_busy  = mem_req_i;
      flush_ev  = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_req_i && !mem_ready_i) begin
               ops     = freeze_ops();
               state_d = ST_MEM_WAIT;
               wait_d  = WAIT_W'(1);
            end else begin
               resolve = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (!mem_ready_i) begin
               if (wait_q >= WAIT_TRIP) begin
                  ops       = all_ops(RST_OP);
                  timeout_d = 1'b1;
                  state_d   = ST_RUN;
                  wait_d    = '0;
               end else begin
                  ops    = freeze_ops();
                  wait_d = wait_q + WAIT_W'(1);
               end
            end else begin
               // The completing access still owns the bus this cycle.
               resolve  = 1'b1;
               bus_busy = 1'b1;
               state_d  = ST_RUN;
               wait_d   = '0;
            end
         end
         default: begin
            state_d = ST_RUN;
            wait_d  = '0;
         end
      endcase

      if (resolve) begin
         if (lu) begin
            ops.pc    = KEEP_OP;
            ops.if_id = KEEP_OP;
            ops.id_ex = RST_OP;
         end else if (branch_taken_i) begin
            ops.if_id = RST_OP;
            flush_ev  = 1'b1;
         end else if (bus_busy) begin
            ops.pc    = KEEP_OP;
            ops.if_id = RST_OP;
         end
      end

      if (!rst) begin
         ops = all_ops(RST_OP);
      end
   end

   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (ops.pc != NORMAL_OP) begin
         stall_d = stall_q + 32'd1;
      end
      if (flush_ev && (flush_q != 16'hFFFF)) begin
         flush_d = flush_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= ST_RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         stall_q   <= ZeroWord;
         flush_q   <= ZeroWord[15:0];
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         stall_q   <= stall_d;
         flush_q   <= flush_d;
      end
   end

   assign pc_op_o        = ops.pc;
   assign if_id_op_o     = ops.if_id;
   assign id_ex_op_o     = ops.id_ex;
   assign ex_mem_op_o    = ops.ex_mem;
   assign mem_wb_op_o    = ops.mem_wb;
   assign mem_timeout_o  = timeout_q;
   assign stall_cycles_o = stall_q;
   assign flush_count_o  = flush_q;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// Directed and randomized checks of pipe_flow_ctrl against a rule-table model.
module tb_pipe_flow_ctrl;

   localparam int REG_W    = 5;
   localparam int MAX_WAIT = 15;

   // Expected op vectors {pc, if_id, id_ex, ex_mem, mem_wb}.
   localparam logic [9:0] E_NORMAL = 10'b00_00_00_00_00;
   localparam logic [9:0] E_ALLRST = 10'b10_10_10_10_10;
   localparam logic [9:0] E_FREEZE = 10'b01_01_01_01_10;
   localparam logic [9:0] E_LU     = 10'b01_01_10_00_00;
   localparam logic [9:0] E_BRANCH = 10'b00_10_00_00_00;
   localparam logic [9:0] E_STRUCT = 10'b01_10_00_00_00;

   logic             clk = 1'b0;
   logic             rst;
   logic [REG_W-1:0] id_rs, id_rt, ex_rd;
   logic             rs_used, rt_used, ex_load, br, mreq, mrdy;
   logic [1:0]       pc_op, if_id_op, id_ex_op, ex_mem_op, mem_wb_op;
   logic             tmo;
   logic [31:0]      stalls;
   logic [15:0]      flushes;

   int checks   = 0;
   int failures = 0;

   // Reference model: waiting flag, consecutive wait cycles seen, sticky flag, counters.
   bit          m_wait;
   int          m_waits;
   bit          m_tmo;
   bit [31:0]   m_stall;
   int          m_flush;

   always #5 clk = ~clk;

   pipe_flow_ctrl #(.REG_W(REG_W), .MAX_WAIT(MAX_WAIT)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_rs_i        (id_rs),
      .id_rt_i        (id_rt),
      .id_rs_used_i   (rs_used),
      .id_rt_used_i   (rt_used),
      .ex_load_i      (ex_load),
      .ex_rd_i        (ex_rd),
      .branch_taken_i (br),
      .mem_req_i      (mreq),
      .mem_ready_i    (mrdy),
      .pc_op_o        (pc_op),
      .if_id_op_o     (if_id_op),
      .id_ex_op_o     (id_ex_op),
      .ex_mem_op_o    (ex_mem_op),
      .mem_wb_op_o    (mem_wb_op),
      .mem_timeout_o  (tmo),
      .stall_cycles_o (stalls),
      .flush_count_o  (flushes)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      rst = 1'b1; id_rs = '0; id_rt = '0; ex_rd = '0;
      rs_used = 1'b0; rt_used = 1'b0; ex_load = 1'b0;
      br = 1'b0; mreq = 1'b0; mrdy = 1'b0;
   endtask

   // One clock: check ops combinationally mid-cycle, then advance the model.
   task automatic cycle();
      logic [9:0] e;
      bit lu, fl, n_wait, n_tmo;
      int n_waits;
      @(negedge clk);
      lu = ex_load && (ex_rd != 0) &&
           ((rs_used && id_rs == ex_rd) || (rt_used && id_rt == ex_rd));
      fl = 0; n_wait = 0; n_waits = 0; n_tmo = m_tmo;
      if (!rst) begin
         e = E_ALLRST;
      end else if (m_wait && !mrdy) begin
         if (m_waits + 1 >= MAX_WAIT) begin
            e = E_ALLRST; n_tmo = 1;
         end else begin
            e = E_FREEZE; n_wait = 1; n_waits = m_waits + 1;
         end
      end else if (!m_wait && mreq && !mrdy) begin
         e = E_FREEZE; n_wait = 1; n_waits = 1;
      end else if (lu) begin
         e = E_LU;
      end else if (br) begin
         e = E_BRANCH; fl = 1;
      end else if (mreq || m_wait) begin
         e = E_STRUCT;
      end else begin
         e = E_NORMAL;
      end

      chk("ops", {22'd0, pc_op, if_id_op, id_ex_op, ex_mem_op, mem_wb_op}, {22'd0, e});
      chk("timeout", {31'd0, tmo}, {31'd0, m_tmo});
      chk("stalls", stalls, m_stall);
      chk("flushes", {16'd0, flushes}, m_flush);

      if (!rst) begin
         m_wait = 0; m_waits = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
      end else begin
         m_wait = n_wait; m_waits = n_waits; m_tmo = n_tmo;
         if (e[9:8] != 2'b00) m_stall = m_stall + 1;
         if (fl && m_flush < 65535) m_flush++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int n);
      idle();
      rst = 1'b0;
      repeat (n) cycle();
      rst = 1'b1;
   endtask

   initial begin
      int hang;
      idle();
      m_wait = 0; m_waits = 0; m_tmo = 0; m_stall = 0; m_flush = 0;
      #1;

      // Reset, then release with idle inputs
      do_reset(2);
      chk("rst_stalls", stalls, 32'd0);
      chk("rst_flushes", {16'd0, flushes}, 32'd0);
      cycle();

      // Load-use stall, then same pattern against r0
      ex_load = 1; ex_rd = 5; id_rs = 5; rs_used = 1;
      cycle();
      chk("lu_stall", stalls, 32'd1);
      ex_rd = 0; id_rs = 0;
      cycle();
      chk("lu_r0_stall", stalls, 32'd1);

      // Three wait cycles then ready
      do_reset(1);
      mreq = 1; mrdy = 0;
      repeat (3) cycle();
      mrdy = 1;
      cycle();
      idle();
      cycle();
      chk("memwait_stall", stalls, 32'd4);

      // Branch with structural conflict, then load-use over branch
      do_reset(1);
      br = 1; mreq = 1; mrdy = 1;
      cycle();
      chk("br_flush", {16'd0, flushes}, 32'd1);
      idle();
      br = 1; ex_load = 1; ex_rd = 7; id_rt = 7; rt_used = 1;
      cycle();
      chk("prio_flush", {16'd0, flushes}, 32'd1);

      // Watchdog trip on the 15th wait cycle, sticky until reset
      do_reset(1);
      mreq = 1; mrdy = 0;
      repeat (MAX_WAIT) cycle();
      chk("wd_tmo", {31'd0, tmo}, 32'd1);
      idle();
      repeat (3) cycle();
      chk("wd_sticky", {31'd0, tmo}, 32'd1);
      do_reset(1);
      chk("wd_clear", {31'd0, tmo}, 32'd0);

      // Reset in the middle of a wait aborts it without a timeout
      mreq = 1; mrdy = 0;
      repeat (4) cycle();
      rst = 0;
      cycle();
      idle();
      repeat (2) cycle();
      chk("abort_tmo", {31'd0, tmo}, 32'd0);

      // Stray ready in RUN
      mrdy = 1;
      cycle();

      // Randomized traffic with occasional long bus stalls
      hang = 0;
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 199) != 0);
         id_rs   = REG_W'($urandom_range(0, 3));
         id_rt   = REG_W'($urandom_range(0, 3));
         ex_rd   = REG_W'($urandom_range(0, 3));
         rs_used = ($urandom_range(0, 9) < 7);
         rt_used = ($urandom_range(0, 9) < 7);
         ex_load = $urandom_range(0, 1) != 0;
         br      = ($urandom_range(0, 4) == 0);
         mreq    = ($urandom_range(0, 9) < 4);
         if (hang > 0) begin
            mrdy = 0;
            mreq = 1;
            hang--;
         end else begin
            if ($urandom_range(0, 99) == 0) hang = $urandom_range(10, 20);
            mrdy = ($urandom_range(0, 2) != 0);
         end
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
